// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
);
   logic              req0_valid;
   logic              req1_valid;
   logic              req0_ready;
   logic              req1_ready;
   logic [DATA_W-1:0] req0_in1;
   logic [DATA_W-1:0] req0_in2;
   logic [DATA_W-1:0] req1_in1;
   logic [DATA_W-1:0] req1_in2;
   logic [CTRL_W-1:0] req0_ctrl;
   logic [CTRL_W-1:0] req1_ctrl;
   logic [DATA_W-1:0] alu_in1;
   logic [DATA_W-1:0] alu_in2;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [DATA_W-1:0] alu_out;
   logic              alu_flag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_flag;
   logic              rsp_src;

   modport slave (
      input  req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
      input  req0_ctrl, req1_ctrl, alu_out, alu_flag, rsp_ready,
      output req0_ready, req1_ready, alu_in1, alu_in2, alu_ctrl,
      output rsp_valid, rsp_data, rsp_flag, rsp_src
   );

   modport master (
      output req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
      output req0_ctrl, req1_ctrl, alu_out, alu_flag, rsp_ready,
      input  req0_ready, req1_ready, alu_in1, alu_in2, alu_ctrl,
      input  rsp_valid, rsp_data, rsp_flag, rsp_src
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port arbiter feeding a shared ALU through an
// issue register, with a result register returned under valid/ready.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
) (
   input logic         clk,
   input logic         rst_n,
   alu_arbiter_if.slave io_bus
);
   logic              r_iss_valid;
   logic [DATA_W-1:0] r_iss_in1;
   logic [DATA_W-1:0] r_iss_in2;
   logic [CTRL_W-1:0] r_iss_ctrl;
   logic              r_iss_src;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_flag;
   logic              r_rsp_src;
   logic              r_last_grant;

   logic              w_res_load;
   logic              w_iss_load;
   logic              w_winner;
   logic              w_accept;
   logic [DATA_W-1:0] w_in1;
   logic [DATA_W-1:0] w_in2;
   logic [CTRL_W-1:0] w_ctrl;

   assign w_res_load = r_iss_valid & (!r_rsp_valid | io_bus.rsp_ready);
   assign w_iss_load = !r_iss_valid | w_res_load;
   assign w_winner   = (io_bus.req0_valid & io_bus.req1_valid) ? !r_last_grant : io_bus.req1_valid;
   // rst_n gates acceptance so no ready is seen while reset is held
   assign w_accept   = rst_n & w_iss_load & (io_bus.req0_valid | io_bus.req1_valid);

   assign w_in1  = w_winner ? io_bus.req1_in1  : io_bus.req0_in1;
   assign w_in2  = w_winner ? io_bus.req1_in2  : io_bus.req0_in2;
   assign w_ctrl = w_winner ? io_bus.req1_ctrl : io_bus.req0_ctrl;

   assign io_bus.req0_ready = w_accept & !w_winner & io_bus.req0_valid;
   assign io_bus.req1_ready = w_accept &  w_winner & io_bus.req1_valid;

   assign io_bus.alu_in1  = r_iss_in1;
   assign io_bus.alu_in2  = r_iss_in2;
   assign io_bus.alu_ctrl = r_iss_ctrl;

   assign io_bus.rsp_valid = r_rsp_valid;
   assign io_bus.rsp_data  = r_rsp_data;
   assign io_bus.rsp_flag  = r_rsp_flag;
   assign io_bus.rsp_src   = r_rsp_src;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iss_valid  <= 1'b0;
         r_iss_in1    <= '0;
         r_iss_in2    <= '0;
         r_iss_ctrl   <= '0;
         r_iss_src    <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_iss_load) begin
         r_iss_valid <= w_accept;
         if (w_accept) begin
            r_iss_in1    <= w_in1;
            r_iss_in2    <= w_in2;
            r_iss_ctrl   <= w_ctrl;
            r_iss_src    <= w_winner;
            r_last_grant <= w_winner;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_flag  <= 1'b0;
         r_rsp_src   <= 1'b0;
      end else if (w_res_load) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= io_bus.alu_out;
         r_rsp_flag  <= io_bus.alu_flag;
         r_rsp_src   <= r_iss_src;
      end else if (io_bus.rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a
// transaction-level model (in-flight queue, capacity 2, round-robin pointer).
module tb_alu_arbiter;
   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, BLT = 5'd8, BLTU = 5'd9;

   typedef struct packed {logic [31:0] a; logic [31:0] b; logic [4:0] c;} req_t;
   typedef struct {logic [31:0] d; logic f; logic s; int t;} exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_arbiter_if bus();
   alu_arbiter dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

   logic       pv [2];
   req_t       pr [2];
   exp_t       q [$];
   int         glog [$];
   int         total = 0, bad = 0, edges = 0, ndone = 0;
   logic       last = 1'b1;
   logic [4:0] ops [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10};

   function automatic logic [32:0] alu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        f;
      r = c == 0 ? a + b : c == 1 ? a - b : c == 2 ? a & b : c == 3 ? a | b : c == 4 ? a ^ b : a - b;
      f = c == 8 ? ($signed(a) < $signed(b)) : c == 9 ? (a < b) : c == 10 ? (a == b) : (r == 0);
      return {f, r};
   endfunction

   assign {bus.alu_flag, bus.alu_out} = alu_fn(bus.alu_ctrl, bus.alu_in1, bus.alu_in2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, want, $time);
      end
   endtask

   task automatic put(input int p, input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
      pv[p] = 1'b1;
      pr[p] = '{a: a, b: b, c: c};
   endtask

   task automatic rnd(input int p);
      if (!pv[p]) put(p, $urandom, $urandom, ops[$urandom_range(0, 7)]);
   endtask

   task automatic drive(input logic rr);
      bus.req0_valid = pv[0];
      bus.req0_in1   = pr[0].a;
      bus.req0_in2   = pr[0].b;
      bus.req0_ctrl  = pr[0].c;
      bus.req1_valid = pv[1];
      bus.req1_in1   = pr[1].a;
      bus.req1_in2   = pr[1].b;
      bus.req1_ctrl  = pr[1].c;
      bus.rsp_ready  = rr;
   endtask

   // one clock: check against the model, then advance the model by the rules
   task automatic cycle(input logic rr);
      logic        w, acc, ev;
      logic [32:0] fr;
      drive(rr);
      #1;
      ev = 1'b0;
      if (q.size() > 0) ev = q[0].t < edges;
      acc = (pv[0] | pv[1]) && !(q.size() == 2 && !rr);
      w   = (pv[0] & pv[1]) ? !last : pv[1];
      chk("ready0", bus.req0_ready, acc & !w);
      chk("ready1", bus.req1_ready, acc & w);
      chk("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
         chk("rsp_data", bus.rsp_data, q[0].d);
         chk("rsp_flag", bus.rsp_flag, q[0].f);
         chk("rsp_src", bus.rsp_src, q[0].s);
      end
      @(posedge clk);
      edges++;
      if (ev & rr) begin
         void'(q.pop_front());
         ndone++;
      end
      if (acc) begin
         fr = alu_fn(pr[w].c, pr[w].a, pr[w].b);
         q.push_back('{d: fr[31:0], f: fr[32], s: w, t: edges});
         last  = w;
         pv[w] = 1'b0;
         glog.push_back(int'(w));
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (q.size() > 0 || pv[0] || pv[1]); i++) cycle(1'b1);
      chk("drained", q.size() + int'(pv[0]) + int'(pv[1]), 0);
   endtask

   initial begin
      int n0, sent;
      rst_n = 1'b0;
      pr[0] = '0;
      pr[1] = '0;
      put(0, 1, 2, ADD);
      put(1, 3, 4, ADD);
      drive(1'b1);
      #2;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_alu_ctrl", bus.alu_ctrl, 0);
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      put(0, 5, 3, SUB);
      cycle(1'b1);
      cycle(1'b1);
      chk("sub_valid", bus.rsp_valid, 1);
      chk("sub_data", bus.rsp_data, 2);
      chk("sub_src", bus.rsp_src, 0);
      drain();

      put(1, 32'hFFFF_FFFF, 1, BLT);
      cycle(1'b1);
      cycle(1'b1);
      chk("blt_flag", bus.rsp_flag, 1);
      chk("blt_src", bus.rsp_src, 1);
      drain();
      put(1, 32'hFFFF_FFFF, 1, BLTU);
      cycle(1'b1);
      cycle(1'b1);
      chk("bltu_flag", bus.rsp_flag, 0);
      drain();

      glog.delete();
      for (int i = 0; i < 6; i++) begin
         rnd(0);
         rnd(1);
         cycle(1'b1);
      end
      chk("rr_count", glog.size(), 6);
      for (int i = 0; i < glog.size() && i < 6; i++) chk("rr_grant", glog[i], i % 2);
      drain();

      glog.delete();
      for (int i = 0; i < 10 && glog.size() < 3; i++) begin
         if (glog.size() + int'(pv[1]) < 3) rnd(1);
         cycle(1'b1);
      end
      drain();
      rnd(0);
      rnd(1);
      glog.delete();
      cycle(1'b1);
      chk("idle_fair", glog.size() > 0 ? glog[0] : -1, 0);
      drain();

      n0   = ndone;
      sent = 0;
      for (int i = 0; i < 20 && (sent < 4 || q.size() > 0 || pv[1]); i++) begin
         if (sent < 4 && !pv[1]) begin
            put(1, $urandom, $urandom, ADD);
            sent++;
         end
         cycle(!(i >= 2 && i < 5));
      end
      chk("bp_results", ndone - n0, 4);

      for (int i = 0; i < 4; i++) begin
         rnd(0);
         rnd(1);
         cycle(1'b0);
      end
      rnd(0);
      rnd(1);
      rst_n = 1'b0;
      drive(1'b1);
      #1;
      chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
      chk("mid_rst_ready0", bus.req0_ready, 0);
      chk("mid_rst_ready1", bus.req1_ready, 0);
      chk("mid_rst_alu_ctrl", bus.alu_ctrl, 0);
      q.delete();
      last  = 1'b1;
      edges = 0;
      @(negedge clk);
      rst_n = 1'b1;
      glog.delete();
      cycle(1'b1);
      chk("post_rst_first", glog.size() > 0 ? glog[0] : -1, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) rnd(0);
         if ($urandom_range(0, 3) != 0) rnd(1);
         cycle($urandom_range(0, 3) != 0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and pipeline sequencer for the shared 32-bit ALU. Grants one operation per cycle to either requester with round-robin fairness, registers the winning operands into an issue stage that drives the ALU, and captures ALU outputs into a result register. The result register is returned to the requester with valid/ready backpressure. It sits between the integer issue logic (port 0) and the branch/address-generation logic (port 1) and the single ALU instance.

## Interface
- DATA_W, 32, operand/result width (matches ALU)
- CTRL_W, 5, ALU operation code width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid, req1_valid  in  1 each  request present on port k
- req0_ready, req1_ready  out  1 each  port k request accepted this cycle (valid & ready)
- req0_in1, req0_in2, req1_in1, req1_in2  in  DATA_W each  operands
- req0_ctrl, req1_ctrl  in  CTRL_W each  ALU operation code
- alu_in1, alu_in2  out  DATA_W  to ALU, driven from issue register
- alu_ctrl  out  CTRL_W  to ALU control, driven from issue register
- alu_out  in  DATA_W  ALU result
- alu_flag  in  1  ALU branch-compare flag
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  registered alu_out
- rsp_flag  out  1  registered alu_flag
- rsp_src  out  1  requester that issued this result (0/1)

## Operation
- State: issue stage {iss_valid, iss_in1, iss_in2, iss_ctrl, iss_src}; result stage {rsp_valid, rsp_data, rsp_flag, rsp_src}; round-robin pointer last_grant.
- res_load = iss_valid & (!rsp_valid | rsp_ready); iss_load = !iss_valid | res_load.
- Arbitration: only one valid -> it wins; both valid -> winner = !last_grant; none -> no grant.
- reqk_ready = iss_load & (winner == k) & reqk_valid; at most one ready high per cycle.
- On accept: issue regs <= winner's operands/ctrl, iss_src <= k, iss_valid <= 1, last_grant <= k.
- iss_load with no accept: iss_valid <= 0, operand/ctrl regs hold.
- last_grant changes only on an accepted transfer; no accept leaves it unchanged.
- On res_load: rsp_data <= alu_out, rsp_flag <= alu_flag, rsp_src <= iss_src, rsp_valid <= 1.
- If rsp_valid & rsp_ready & !res_load: rsp_valid <= 0; data regs hold.
- ALU ports always reflect the issue regs; ALU output is ignored when iss_valid = 0.
- Operations are opaque: the block never decodes ctrl. alu_flag is captured for every op, and the consumer interprets it.
- Requesters must not make valid depend on ready; valid and payload are held until accepted.
- Reset (async, any time, including mid-transfer): iss_valid = 0, rsp_valid = 0, all data/ctrl regs = 0, alu_ctrl = 0, last_grant = 1 (port 0 wins first tie), reqk_ready = 0. In-flight ops are dropped.

## Timing
- Latency: accept at edge N -> result in rsp_* with rsp_valid = 1 after edge N+1.
- Throughput: 1 op/cycle sustained when rsp_ready = 1.
- Full pipeline (both stages valid) with rsp_ready = 0: iss_load = 0, both readies low, all state holds.
- rsp_ready rising while full: result drains, issue advances into result, and a new request is accepted in the same cycle. No bubble.
- Capacity: 2 ops in flight; no further buffering.
- Ready is combinational from reqk_valid, rsp_ready and state; no combinational path from alu_out to any ready.

## Test plan
- Reset: rst_n low mid-stream with both stages valid -> immediately rsp_valid = 0, ready low, alu_ctrl = 0; after release, simultaneous requests -> port 0 accepted first.
- Single op: req0 in1 = 5, in2 = 3, ctrl = SUB, rsp_ready = 1 -> accept at edge N; after N+1: rsp_valid = 1, rsp_data = 2, rsp_src = 0.
- Round-robin: both ports valid continuously for 6 cycles, rsp_ready = 1 -> grants alternate 0,1,0,1,0,1; rsp_src follows the same sequence 2 cycles later.
- Backpressure: stream 4 ADDs from port 1, rsp_ready low for 3 cycles after the first result -> exactly 2 ops in flight, readies low, rsp_data stable; on release, all 4 results arrive in order with none lost or duplicated.
- Flag path: req1 ctrl = BLT, in1 = 0xFFFFFFFF, in2 = 1 -> rsp_flag = 1, rsp_src = 1; ctrl = BLTU, same operands -> rsp_flag = 0.
- Idle fairness: port 1 alone for 3 ops, then both valid -> port 0 wins (last_grant = 1).
